// File: rtl/branch_hazard_pkg.sv
// Shared constants and types for the ID-stage branch hazard scoreboard.
package branch_hazard_pkg;

  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned BUSY_W      = 2;
  localparam int unsigned STALL_CNT_W = 16;

  typedef logic [BUSY_W-1:0] busy_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  localparam busy_t LOAD_LAT = 2'd2;
  localparam busy_t ALU_LAT  = 2'd1;

  // Destination of the most recent register-writing issue, so a flush can undo it.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } issue_rec_t;

  function automatic busy_t issue_latency(input logic is_load);
    return is_load ? LOAD_LAT : ALU_LAT;
  endfunction

endpackage

// File: rtl/branch_hazard_scoreboard_if.sv
// ID-stage request / stall-response bundle between pipeline control and the scoreboard.
interface branch_hazard_scoreboard_if;
  import branch_hazard_pkg::*;

  logic                   id_valid;
  logic                   id_is_branch;
  reg_idx_t               id_rs1;
  reg_idx_t               id_rs2;
  reg_idx_t               id_rd;
  logic                   id_regwr_en;
  logic                   id_is_load;
  logic                   ex_flush;
  logic                   ext_stall;
  logic                   stall_id;
  logic                   stall_rs1;
  logic                   stall_rs2;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_is_branch, id_rs1, id_rs2, id_rd, id_regwr_en, id_is_load,
           ex_flush, ext_stall,
    input  stall_id, stall_rs1, stall_rs2, stall_cycles
  );

  modport slave (
    input  id_valid, id_is_branch, id_rs1, id_rs2, id_rd, id_regwr_en, id_is_load,
           ex_flush, ext_stall,
    output stall_id, stall_rs1, stall_rs2, stall_cycles
  );

endinterface

// File: rtl/branch_hazard_scoreboard_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;

  // Next value: step by one unless already saturated.
  always_comb begin
    count_nxt = count_q;
    if (inc && (count_q != '1)) begin
      count_nxt = count_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// Tracks in-flight register writes and stalls ID-stage branches whose sources are not ready.
module branch_hazard_scoreboard
  import branch_hazard_pkg::*;
(
  input logic                       clk,
  input logic                       rst_n,
  branch_hazard_scoreboard_if.slave hz
);

  busy_t      busy_q [NUM_REGS];
  issue_rec_t last_q;

  logic stall_rs1;
  logic stall_rs2;
  logic stall_id;
  logic issue;
  logic set_en;
  logic flush_clr;

  // Per-source hazard detection; only branches resolve in ID so only they wait.
  always_comb begin
    stall_rs1 = hz.id_valid & hz.id_is_branch & (hz.id_rs1 != '0) & (busy_q[hz.id_rs1] != '0);
    stall_rs2 = hz.id_valid & hz.id_is_branch & (hz.id_rs2 != '0) & (busy_q[hz.id_rs2] != '0);
    stall_id  = (stall_rs1 | stall_rs2) & ~hz.ex_flush;
    issue     = hz.id_valid & ~stall_id & ~hz.ext_stall & ~hz.ex_flush;
    set_en    = issue & hz.id_regwr_en & (hz.id_rd != '0);
    flush_clr = hz.ex_flush & last_q.valid;
  end

  // Busy countdowns and last-issue record; everything freezes under ext_stall.
  // Priority per entry: new issue set, then flush clear, then decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= '0;
      end
      last_q <= '0;
    end else if (!hz.ext_stall) begin
      last_q.valid <= set_en;
      last_q.rd    <= hz.id_rd;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (r == 0) begin
          busy_q[r] <= '0;
        end else if (set_en && (hz.id_rd == reg_idx_t'(r))) begin
          busy_q[r] <= issue_latency(hz.id_is_load);
        end else if (flush_clr && (last_q.rd == reg_idx_t'(r))) begin
          busy_q[r] <= '0;
        end else if (busy_q[r] != '0) begin
          busy_q[r] <= busy_q[r] - 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_id & ~hz.ext_stall),
    .count (hz.stall_cycles)
  );

  assign hz.stall_rs1 = stall_rs1;
  assign hz.stall_rs2 = stall_rs2;
  assign hz.stall_id  = stall_id;

endmodule
